step_rx: RTL and testbench

Step/direction receiver for the motion path: the far end of the stepper pulse generator's `step` output. It synchronises an asynchronous step/dir pair, qualifies step pulses against a minimum high width, and keeps a signed position count. It also measures the step period, flags motion and timeout, and raises a done flag after a programmed number of steps. It sits at the driver input stage or in a loop-back monitor that checks the generator's output.

---
 rtl/step_pkg.sv | 16 +
 rtl/sync2.sv | 24 ++
 rtl/step_rx.sv | 158 +++++++++++++++
 tb/tb_step_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared types for the step/direction path: receiver FSM states and the
// direction encoding the pulse generator also drives.
package step_pkg;

  typedef enum logic [2:0] {
    WAIT_LOW = 3'd0,
    IDLE     = 3'd1,
    QUAL     = 3'd2,
    ACC_HIGH = 3'd3,
    LOW      = 3'd4
  } state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous level; both flops clear to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/step_rx.sv
// Step/direction receiver: qualifies step pulses by high width, tracks a signed
// position, step count, step period, motion/timeout and a count-reached flag.
module step_rx
  import step_pkg::*;
#(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned POS_W    = 32,
  parameter int unsigned MIN_HIGH = 2,
  parameter int unsigned TIMEOUT  = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             clr,
  input  logic [SIZE-1:0]  n,
  output logic [POS_W-1:0] position,
  output logic [SIZE-1:0]  step_cnt,
  output logic [SIZE-1:0]  period,
  output logic             period_valid,
  output logic             moving,
  output logic             step_pulse,
  output logic             glitch_err,
  output logic             count_done,
  output logic [2:0]       fsm_state
);

  localparam int unsigned HCNT_W = (MIN_HIGH < 2) ? 1 : $clog2(MIN_HIGH + 1);
  // hcnt holds the high samples seen before the current one, so the
  // MIN_HIGH-th sample accepts when hcnt reaches MIN_HIGH-1.
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(MIN_HIGH - 1);

  logic s;
  logic d;

  sync2 u_sync_step (.clk(clk), .rst(rst), .d_i(step_in), .q_o(s));
  sync2 u_sync_dir  (.clk(clk), .rst(rst), .d_i(dir_in),  .q_o(d));

  state_t             state_q, state_d;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic [1:0]         prime_q;
  logic [SIZE-1:0]    pcnt_q;
  logic [POS_W-1:0]   position_q;
  logic [SIZE-1:0]    step_cnt_q;
  logic [SIZE-1:0]    period_q;
  logic               period_valid_q;
  logic               moving_q;
  logic               step_pulse_q;
  logic               glitch_err_q;
  logic               count_done_q;
  logic               accept;
  logic               glitch;
  logic               timeout;
  logic [SIZE-1:0]    step_cnt_inc;

  assign timeout      = moving_q && (pcnt_q == SIZE'(TIMEOUT));
  assign step_cnt_inc = step_cnt_q + SIZE'(1);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    accept  = 1'b0;
    glitch  = 1'b0;
    case (state_q)
      // prime_q keeps the reset-cleared synchroniser from passing for a low line
      WAIT_LOW: if (prime_q[1] && !s) state_d = IDLE;
      IDLE, LOW: begin
        if (s) begin
          if (MIN_HIGH == 1) begin
            accept  = 1'b1;
            state_d = ACC_HIGH;
          end else begin
            hcnt_d  = HCNT_W'(1);
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        if (s) begin
          if (hcnt_q == HCNT_LAST) begin
            accept  = 1'b1;
            state_d = ACC_HIGH;
          end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end
        end else begin
          glitch  = 1'b1;
          state_d = moving_q ? LOW : IDLE;
        end
      end
      ACC_HIGH: if (!s) state_d = LOW;
      default:  state_d = WAIT_LOW;
    endcase
    // A line still high at timeout is treated as stuck and must drop first.
    if (timeout && !accept) begin
      if (state_q == QUAL || state_q == ACC_HIGH) state_d = WAIT_LOW;
      else if (state_q == LOW)                    state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_LOW;
      hcnt_q         <= '0;
      prime_q        <= '0;
      pcnt_q         <= '0;
      position_q     <= '0;
      step_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      moving_q       <= 1'b0;
      step_pulse_q   <= 1'b0;
      glitch_err_q   <= 1'b0;
      count_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      prime_q      <= {prime_q[0], 1'b1};
      step_pulse_q <= accept;
      glitch_err_q <= glitch;

      if (accept)              pcnt_q <= SIZE'(1);
      else if (pcnt_q != '1)   pcnt_q <= pcnt_q + SIZE'(1);

      if (accept) begin
        if (moving_q) begin
          period_q       <= pcnt_q;
          period_valid_q <= 1'b1;
        end
        moving_q <= 1'b1;
      end else if (timeout) begin
        moving_q       <= 1'b0;
        period_valid_q <= 1'b0;
      end

      if (clr) begin
        position_q   <= '0;
        step_cnt_q   <= '0;
        count_done_q <= 1'b0;
      end else if (accept) begin
        position_q <= (d == DIR_POS) ? position_q + POS_W'(1) : position_q - POS_W'(1);
        step_cnt_q <= step_cnt_inc;
        if (n != '0 && step_cnt_inc == n) count_done_q <= 1'b1;
      end
    end
  end

  assign position     = position_q;
  assign step_cnt     = step_cnt_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign moving       = moving_q;
  assign step_pulse   = step_pulse_q;
  assign glitch_err   = glitch_err_q;
  assign count_done   = count_done_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_step_rx.sv
// Directed bench for step_rx with hand-computed expectations at default parameters.
module tb_step_rx;
  import step_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_in;
  logic        dir_in;
  logic        clr;
  logic [15:0] n;
  logic [31:0] position;
  logic [15:0] step_cnt;
  logic [15:0] period;
  logic        period_valid;
  logic        moving;
  logic        step_pulse;
  logic        glitch_err;
  logic        count_done;
  logic [2:0]  fsm_state;

  int n_vec = 0;
  int n_bad = 0;
  int pulse_seen = 0;
  int glitch_seen = 0;
  int base_p;
  int base_g;

  step_rx dut (
    .clk(clk), .rst(rst), .step_in(step_in), .dir_in(dir_in), .clr(clr), .n(n),
    .position(position), .step_cnt(step_cnt), .period(period),
    .period_valid(period_valid), .moving(moving), .step_pulse(step_pulse),
    .glitch_err(glitch_err), .count_done(count_done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && step_pulse) pulse_seen++;
    if (!rst && glitch_err) glitch_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    step_in = 1'b0;
    clr     = 1'b0;
    rst     = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  // Raise the line and confirm the accept strobe lands on the 4th edge.
  task automatic step_rise(input logic dir, input string tag);
    dir_in  = dir;
    step_in = 1'b1;
    repeat (3) tick();
    check_eq({tag, "_early"}, {31'b0, step_pulse}, 32'd0);
    tick();
    check_eq({tag, "_pulse"}, {31'b0, step_pulse}, 32'd1);
  endtask

  task automatic full_pulse(input logic dir, input string tag);
    step_rise(dir, tag);
    repeat (6) tick();
    step_in = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    dir_in  = 1'b1;
    clr     = 1'b0;
    n       = '0;
    step_in = 1'b1;
    rst     = 1'b1;
    repeat (3) tick();
    check_eq("rst_pos", position, 32'd0);
    check_eq("rst_cnt", {16'b0, step_cnt}, 32'd0);
    check_eq("rst_mov", {31'b0, moving}, 32'd0);
    check_eq("rst_st", {29'b0, fsm_state}, 32'(WAIT_LOW));

    // Line held high across reset release must not count.
    base_p = pulse_seen;
    rst = 1'b0;
    repeat (50) tick();
    check_eq("hi_rst_pulses", pulse_seen - base_p, 32'd0);
    check_eq("hi_rst_pos", position, 32'd0);
    check_eq("hi_rst_st", {29'b0, fsm_state}, 32'(WAIT_LOW));
    step_in = 1'b0;
    repeat (5) tick();
    check_eq("drop_st", {29'b0, fsm_state}, 32'(IDLE));
    step_rise(DIR_POS, "first");
    repeat (6) tick();
    step_in = 1'b0;
    repeat (10) tick();
    check_eq("first_pulses", pulse_seen - base_p, 32'd1);
    check_eq("first_pos", position, 32'd1);
    check_eq("first_pv", {31'b0, period_valid}, 32'd0);

    // Five steps, period 20.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_rise(DIR_POS, "train");
      check_eq("train_pos", position, 32'(i + 1));
      check_eq("train_pv", {31'b0, period_valid}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check_eq("train_per", {16'b0, period}, 32'd20);
      repeat (6) tick();
      step_in = 1'b0;
      repeat (10) tick();
    end
    check_eq("train_cnt", {16'b0, step_cnt}, 32'd5);

    // Single-sample pulse is rejected.
    base_p = pulse_seen;
    base_g = glitch_seen;
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    repeat (10) tick();
    check_eq("glitch_strobes", glitch_seen - base_g, 32'd1);
    check_eq("glitch_pulses", pulse_seen - base_p, 32'd0);
    check_eq("glitch_pos", position, 32'd5);
    check_eq("glitch_cnt", {16'b0, step_cnt}, 32'd5);

    // Up 3, down 5.
    do_reset();
    for (int i = 0; i < 3; i++) full_pulse(DIR_POS, "up");
    for (int i = 0; i < 5; i++) full_pulse(DIR_NEG, "down");
    check_eq("updown_pos", position, 32'hFFFF_FFFE);
    check_eq("updown_cnt", {16'b0, step_cnt}, 32'd8);

    // Timeout with the line low.
    do_reset();
    for (int i = 0; i < 2; i++) full_pulse(DIR_POS, "to");
    step_rise(DIR_POS, "to_last");
    repeat (6) tick();
    step_in = 1'b0;
    repeat (3993) tick();
    check_eq("to_mov_before", {31'b0, moving}, 32'd1);
    check_eq("to_pv_before", {31'b0, period_valid}, 32'd1);
    tick();
    check_eq("to_mov_after", {31'b0, moving}, 32'd0);
    check_eq("to_pv_after", {31'b0, period_valid}, 32'd0);
    check_eq("to_per_kept", {16'b0, period}, 32'd20);
    check_eq("to_st", {29'b0, fsm_state}, 32'(IDLE));

    // Timeout with the line stuck high.
    do_reset();
    for (int i = 0; i < 2; i++) full_pulse(DIR_POS, "stk");
    step_rise(DIR_POS, "stk_last");
    repeat (3999) tick();
    check_eq("stk_st_before", {29'b0, fsm_state}, 32'(ACC_HIGH));
    tick();
    check_eq("stk_mov", {31'b0, moving}, 32'd0);
    check_eq("stk_st", {29'b0, fsm_state}, 32'(WAIT_LOW));
    repeat (20) tick();
    check_eq("stk_cnt_hold", {16'b0, step_cnt}, 32'd3);
    step_in = 1'b0;
    repeat (5) tick();
    check_eq("stk_st_idle", {29'b0, fsm_state}, 32'(IDLE));
    step_rise(DIR_POS, "stk_resume");
    check_eq("stk_cnt_resume", {16'b0, step_cnt}, 32'd4);
    step_in = 1'b0;
    repeat (10) tick();

    // count_done at n=3, then clr colliding with an accept.
    do_reset();
    n = 16'd3;
    for (int i = 0; i < 4; i++) begin
      step_rise(DIR_POS, "cd");
      check_eq("cd_flag", {31'b0, count_done}, (i >= 2) ? 32'd1 : 32'd0);
      repeat (6) tick();
      step_in = 1'b0;
      repeat (10) tick();
    end
    dir_in  = DIR_POS;
    step_in = 1'b1;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_pulse", {31'b0, step_pulse}, 32'd1);
    check_eq("clr_pos", position, 32'd0);
    check_eq("clr_cnt", {16'b0, step_cnt}, 32'd0);
    check_eq("clr_done", {31'b0, count_done}, 32'd0);
    check_eq("clr_per", {16'b0, period}, 32'd20);
    check_eq("clr_pv", {31'b0, period_valid}, 32'd1);
    step_in = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
